// File: rtl/timer_sched_pkg.sv
// Shared constants for the timer channel scheduler: register map, CTRL bit
// positions, scan FSM states and the prescaler reload clamp.
package timer_sched_pkg;

  localparam logic [5:0] A_STATUS   = 6'd0;
  localparam logic [5:0] A_GCTRL    = 6'd1;
  localparam logic [5:0] A_PRESCALE = 6'd2;
  localparam int         CH_BASE    = 8;
  localparam int         CH_STRIDE  = 8;

  localparam logic [2:0] CH_CTRL     = 3'd0;
  localparam logic [2:0] CH_PERIOD_L = 3'd1;
  localparam logic [2:0] CH_PERIOD_H = 3'd2;
  localparam logic [2:0] CH_SNAP_L   = 3'd3;
  localparam logic [2:0] CH_SNAP_H   = 3'd4;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_CONT = 1;
  localparam int CTRL_IE   = 2;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_t;

  // Reload never drops below the channel count, so a scan always ends before the next tick.
  function automatic logic [15:0] clamp_reload(input logic [15:0] v, input int n);
    if (int'(v) < n) return 16'(n);
    return v;
  endfunction

endpackage

// File: rtl/timer_channel_scheduler_if.sv
// Avalon-MM slave bus of the timer scheduler, plus irq and scan-state visibility.
interface timer_channel_scheduler_if;
  import timer_sched_pkg::*;

  // Handshake: a write is accepted in any cycle with chipselect=1 and write_n=0;
  // readdata reflects the register addressed in the previous cycle; no wait states.
  logic        chipselect;
  logic [5:0]  address;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic        irq;
  scan_state_t dbg_state;
  logic [1:0]  dbg_idx;

  modport master (
    output chipselect, address, write_n, writedata,
    input  readdata, irq, dbg_state, dbg_idx
  );

  modport slave (
    input  chipselect, address, write_n, writedata,
    output readdata, irq, dbg_state, dbg_idx
  );

endinterface

// File: rtl/timer_tick_prescaler.sv
// Shared prescaler: 16-bit down counter with a writable reload value,
// emitting a one-cycle tick each time it passes through zero while running.
module timer_tick_prescaler
  import timer_sched_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int PRESCALE_RESET = 49999
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic        load,
  input  logic [15:0] load_value,
  output logic [15:0] reload,
  output logic        tick
);

  logic [15:0] reload_q, reload_d;
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    reload_d = reload_q;
    cnt_d    = cnt_q;
    tick     = 1'b0;
    if (load) begin
      reload_d = load_value;
      cnt_d    = clamp_reload(load_value, NUM_CH);
    end else if (run) begin
      if (cnt_q == 16'd0) begin
        tick  = 1'b1;
        cnt_d = clamp_reload(reload_q, NUM_CH);
      end else begin
        cnt_d = cnt_q - 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reload_q <= 16'(PRESCALE_RESET);
      cnt_q    <= 16'(PRESCALE_RESET);
    end else begin
      reload_q <= reload_d;
      cnt_q    <= cnt_d;
    end
  end

  assign reload = reload_q;

endmodule

// File: rtl/timer_channel_scheduler.sv
// Multi-channel interval timer: one prescaler tick starts a scan that services
// one channel per clock through a shared 32-bit decrement/compare path.
module timer_channel_scheduler
  import timer_sched_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int PRESCALE_RESET = 49999
) (
  input  logic                       clk,
  input  logic                       reset_n,
  timer_channel_scheduler_if.slave   bus
);

  scan_state_t state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic        run_q, run_d;
  logic [15:0] rd_q, rd_d;

  logic [NUM_CH-1:0] en_q, en_d, cont_q, cont_d, ie_q, ie_d, pend_q, pend_d;
  logic [NUM_CH-1:0] pend_set, pend_clr;
  logic [NUM_CH-1:0][31:0] period_q, period_d, count_q, count_d, snap_q, snap_d;

  logic        wr, a_ch_ok, host_hit, tick, presc_load;
  logic [2:0]  a_grp, a_off;
  logic [1:0]  a_ch;
  logic [15:0] presc_reload;

  assign wr         = bus.chipselect && !bus.write_n;
  assign a_grp      = bus.address[5:3];
  assign a_off      = bus.address[2:0];
  assign a_ch       = 2'(a_grp - 3'd1);
  assign a_ch_ok    = (a_grp != 3'd0) && (int'(a_grp) <= NUM_CH);
  assign host_hit   = wr && a_ch_ok &&
                      (a_off == CH_CTRL || a_off == CH_PERIOD_L || a_off == CH_PERIOD_H);
  assign presc_load = wr && (bus.address == A_PRESCALE);

  timer_tick_prescaler #(.NUM_CH(NUM_CH), .PRESCALE_RESET(PRESCALE_RESET)) u_presc (
    .clk        (clk),
    .rst_n      (reset_n),
    .run        (run_q),
    .load       (presc_load),
    .load_value (bus.writedata),
    .reload     (presc_reload),
    .tick       (tick)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    run_d    = run_q;
    en_d     = en_q;
    cont_d   = cont_q;
    ie_d     = ie_q;
    period_d = period_q;
    count_d  = count_q;
    snap_d   = snap_q;
    pend_set = '0;
    pend_clr = '0;
    rd_d     = '0;

    case (state_q)
      IDLE: if (tick) begin
        state_d = SCAN;
        idx_d   = 2'd0;
      end
      SCAN: if (idx_q == 2'(NUM_CH - 1)) state_d = IDLE;
            else idx_d = idx_q + 2'd1;
      default: state_d = IDLE;
    endcase

    // A host write to the same channel's CTRL/PERIOD this cycle discards the service result.
    if (state_q == SCAN && en_q[idx_q] && !(host_hit && a_ch == idx_q)) begin
      if (count_q[idx_q] <= 32'd1) begin
        pend_set[idx_q] = 1'b1;
        if (cont_q[idx_q]) begin
          count_d[idx_q] = period_q[idx_q];
        end else begin
          en_d[idx_q]    = 1'b0;
          count_d[idx_q] = '0;
        end
      end else begin
        count_d[idx_q] = count_q[idx_q] - 32'd1;
      end
    end

    if (wr) begin
      if (bus.address == A_STATUS) pend_clr = bus.writedata[NUM_CH-1:0];
      else if (bus.address == A_GCTRL) run_d = bus.writedata[0];
      else if (a_ch_ok) begin
        case (a_off)
          CH_CTRL: begin
            en_d[a_ch]   = bus.writedata[CTRL_EN];
            cont_d[a_ch] = bus.writedata[CTRL_CONT];
            ie_d[a_ch]   = bus.writedata[CTRL_IE];
            if (bus.writedata[CTRL_EN]) count_d[a_ch] = period_q[a_ch];
          end
          CH_PERIOD_L: period_d[a_ch][15:0]  = bus.writedata;
          CH_PERIOD_H: period_d[a_ch][31:16] = bus.writedata;
          CH_SNAP_L, CH_SNAP_H: snap_d[a_ch] = count_q[a_ch];
          default: ;
        endcase
      end
    end

    pend_d = (pend_q & ~pend_clr) | pend_set;

    if (bus.chipselect) begin
      if (bus.address == A_STATUS)        rd_d = 16'(pend_q);
      else if (bus.address == A_GCTRL)    rd_d = {15'b0, run_q};
      else if (bus.address == A_PRESCALE) rd_d = presc_reload;
      else if (a_ch_ok) begin
        case (a_off)
          CH_CTRL:     rd_d = {13'b0, ie_q[a_ch], cont_q[a_ch], en_q[a_ch]};
          CH_PERIOD_L: rd_d = period_q[a_ch][15:0];
          CH_PERIOD_H: rd_d = period_q[a_ch][31:16];
          CH_SNAP_L:   rd_d = snap_q[a_ch][15:0];
          CH_SNAP_H:   rd_d = snap_q[a_ch][31:16];
          default:     rd_d = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      idx_q    <= 2'd0;
      run_q    <= 1'b0;
      rd_q     <= '0;
      en_q     <= '0;
      cont_q   <= '0;
      ie_q     <= '0;
      pend_q   <= '0;
      period_q <= '0;
      count_q  <= '0;
      snap_q   <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      run_q    <= run_d;
      rd_q     <= rd_d;
      en_q     <= en_d;
      cont_q   <= cont_d;
      ie_q     <= ie_d;
      pend_q   <= pend_d;
      period_q <= period_d;
      count_q  <= count_d;
      snap_q   <= snap_d;
    end
  end

  assign bus.readdata  = rd_q;
  assign bus.irq       = |(pend_q & ie_q);
  assign bus.dbg_state = state_q;
  assign bus.dbg_idx   = idx_q;

endmodule

// File: tb/tb_timer_channel_scheduler.sv
// Bench for timer_channel_scheduler: directed timing scenarios plus randomized
// channel configurations checked against a tick-level behavioural model.
module tb_timer_channel_scheduler;
  import timer_sched_pkg::*;

  localparam int NUM_CH = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  timer_channel_scheduler_if bus_if ();

  timer_channel_scheduler #(.NUM_CH(NUM_CH), .PRESCALE_RESET(49999)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: observed time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  logic [31:0] m_period [NUM_CH];
  logic [31:0] m_count  [NUM_CH];
  bit          m_en [NUM_CH];
  bit          m_cont [NUM_CH];
  bit          m_ie [NUM_CH];
  bit          m_pend [NUM_CH];
  int          first_tick, tick_gap;

  function automatic void model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_period[c] = '0; m_count[c] = '0;
      m_en[c] = 0; m_cont[c] = 0; m_ie[c] = 0; m_pend[c] = 0;
    end
  endfunction

  function automatic void model_tick();
    for (int c = 0; c < NUM_CH; c++) begin
      if (m_en[c]) begin
        if (m_count[c] <= 32'd1) begin
          m_pend[c] = 1;
          if (m_cont[c]) m_count[c] = m_period[c];
          else begin m_en[c] = 0; m_count[c] = '0; end
        end else begin
          m_count[c] = m_count[c] - 32'd1;
        end
      end
    end
  endfunction

  function automatic logic [15:0] model_status();
    logic [15:0] s = '0;
    for (int c = 0; c < NUM_CH; c++) s[c] = m_pend[c];
    return s;
  endfunction

  function automatic logic model_irq();
    logic r = 1'b0;
    for (int c = 0; c < NUM_CH; c++) r = r | (m_pend[c] & m_ie[c]);
    return r;
  endfunction

  function automatic logic [5:0] ch_addr(input int c, input logic [2:0] off);
    return 6'(CH_BASE + CH_STRIDE * c) + 6'(off);
  endfunction

  // ---------------- comparison point ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic bus_write(input logic [5:0] a, input logic [15:0] d);
    bus_if.chipselect = 1'b1; bus_if.write_n = 1'b0;
    bus_if.address = a; bus_if.writedata = d;
    @(posedge clk); #1;
    bus_if.chipselect = 1'b0; bus_if.write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [5:0] a, output logic [15:0] d);
    bus_if.chipselect = 1'b1; bus_if.write_n = 1'b1; bus_if.address = a;
    @(posedge clk); #1;
    d = bus_if.readdata;
    bus_if.chipselect = 1'b0;
  endtask

  task automatic wait_cyc(input int target);
    check("schedule_late", 32'(cyc > target), 32'd0);
    while (cyc < target) begin @(posedge clk); #1; end
  endtask

  task automatic cfg_ch(input int c, input logic [31:0] period, input logic [2:0] ctrl);
    bus_write(ch_addr(c, CH_PERIOD_L), period[15:0]);
    bus_write(ch_addr(c, CH_PERIOD_H), period[31:16]);
    bus_write(ch_addr(c, CH_CTRL), 16'h0001);
    bus_write(ch_addr(c, CH_CTRL), {13'b0, ctrl});
    m_period[c] = period; m_count[c] = period;
    m_en[c] = ctrl[0]; m_cont[c] = ctrl[1]; m_ie[c] = ctrl[2];
  endtask

  task automatic start_run(input int p);
    int g;
    bus_write(A_PRESCALE, 16'(p));
    g = cyc;
    bus_write(A_GCTRL, 16'h0001);
    tick_gap   = ((p < NUM_CH) ? NUM_CH : p) + 1;
    first_tick = g + tick_gap;
  endtask

  task automatic snap_read(input int c, output logic [31:0] v);
    logic [15:0] lo, hi;
    bus_write(ch_addr(c, CH_SNAP_L), 16'h0);
    bus_read(ch_addr(c, CH_SNAP_L), lo);
    bus_read(ch_addr(c, CH_SNAP_H), hi);
    v = {hi, lo};
  endtask

  // Stop the prescaler, fold every tick the DUT saw into the model, then compare all state.
  task automatic stop_and_check(input string tag);
    int s, nt;
    logic [15:0] d;
    logic [31:0] v;
    s = cyc;
    bus_write(A_GCTRL, 16'h0000);
    nt = (s >= first_tick) ? (s - first_tick) / tick_gap + 1 : 0;
    for (int k = 0; k < nt; k++) model_tick();
    repeat (NUM_CH + 3) begin @(posedge clk); #1; end
    bus_read(A_STATUS, d);
    check({tag, "_status"}, 32'(d), 32'(model_status()));
    check({tag, "_irq"}, 32'(bus_if.irq), 32'(model_irq()));
    for (int c = 0; c < NUM_CH; c++) begin
      bus_read(ch_addr(c, CH_CTRL), d);
      check($sformatf("%s_ctrl%0d", tag, c), 32'(d), {29'b0, m_ie[c], m_cont[c], m_en[c]});
      snap_read(c, v);
      check($sformatf("%s_count%0d", tag, c), v, m_count[c]);
    end
    bus_write(A_STATUS, 16'h000F);
    for (int c = 0; c < NUM_CH; c++) m_pend[c] = 0;
  endtask

  // ---------------- directed + randomized sequence ----------------
  initial begin
    logic [15:0] d;
    logic [31:0] v;
    int t0, t2, t5, s, nt;

    bus_if.chipselect = 1'b0; bus_if.write_n = 1'b1;
    bus_if.address = '0; bus_if.writedata = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Reset values
    check("rst_readdata", 32'(bus_if.readdata), 32'd0);
    check("rst_irq", 32'(bus_if.irq), 32'd0);
    check("rst_state", 32'(bus_if.dbg_state), 32'(IDLE));
    bus_read(A_PRESCALE, d); check("rst_prescale", 32'(d), 32'd49999);
    bus_read(ch_addr(0, CH_CTRL), d); check("rst_ch0_ctrl", 32'(d), 32'd0);
    bus_read(A_GCTRL, d); check("rst_gctrl", 32'(d), 32'd0);
    bus_read(6'd5, d); check("unmapped_read", 32'(d), 32'd0);

    // Continuous ch0, period 3, 10-cycle ticks: pending exactly at cycle tick+2
    cfg_ch(0, 32'd3, 3'b111);
    start_run(9);
    t0 = first_tick; t2 = t0 + 2 * tick_gap; t5 = t0 + 5 * tick_gap;
    wait_cyc(t2 + 1); check("t2_irq_early", 32'(bus_if.irq), 32'd0);
    wait_cyc(t2 + 2); check("t2_irq_set", 32'(bus_if.irq), 32'd1);
    wait_cyc(t2 + 20); check("t2_irq_held", 32'(bus_if.irq), 32'd1);
    bus_write(A_STATUS, 16'h0001);
    check("w1c_irq_clear", 32'(bus_if.irq), 32'd0);
    wait_cyc(t5 + 1); check("t5_irq_early", 32'(bus_if.irq), 32'd0);
    wait_cyc(t5 + 2); check("t5_irq_set", 32'(bus_if.irq), 32'd1);
    stop_and_check("cont");

    // One-shot ch1, period 2
    cfg_ch(0, 32'd0, 3'b000);
    cfg_ch(1, 32'd2, 3'b101);
    cfg_ch(2, 32'd0, 3'b000);
    cfg_ch(3, 32'd0, 3'b000);
    start_run(4);
    wait_cyc(cyc + 45);
    stop_and_check("oneshot");

    // Randomized configurations
    for (int t = 0; t < 8; t++) begin
      for (int c = 0; c < NUM_CH; c++)
        cfg_ch(c, 32'($urandom_range(0, 5)), 3'($urandom_range(0, 7)));
      start_run($urandom_range(0, 12));
      wait_cyc(cyc + $urandom_range(10, 90));
      stop_and_check($sformatf("rnd%0d", t));
    end

    // PRESCALE=1 is clamped: all channels pend every tick and scans never overlap
    for (int c = 0; c < NUM_CH; c++) cfg_ch(c, 32'd1, 3'b011);
    start_run(1);
    t0 = first_tick;
    check("clamp_gap", 32'(tick_gap), 32'(NUM_CH + 1));
    wait_cyc(t0 + 1); check("scan_start", 32'(bus_if.dbg_state), 32'(SCAN));
    wait_cyc(t0 + 4); check("scan_last", 32'(bus_if.dbg_state), 32'(SCAN));
    wait_cyc(t0 + 5); check("scan_done", 32'(bus_if.dbg_state), 32'(IDLE));
    bus_read(A_STATUS, d); check("all_pend", 32'(d), 32'h000F);
    bus_write(A_STATUS, 16'h000F);
    bus_read(A_STATUS, d); check("set_beats_clear", 32'(d), 32'h0001);
    wait_cyc(t0 + 10); check("no_overlap", 32'(bus_if.dbg_state), 32'(IDLE));
    bus_read(A_STATUS, d); check("all_pend_again", 32'(d), 32'h000F);
    stop_and_check("clamp");

    // Host CTRL write in the exact cycle ch2 is serviced with count=1
    cfg_ch(0, 32'd0, 3'b000);
    cfg_ch(1, 32'd0, 3'b000);
    cfg_ch(2, 32'd1, 3'b101);
    cfg_ch(3, 32'd0, 3'b000);
    start_run(9);
    wait_cyc(first_tick + 3);
    bus_write(ch_addr(2, CH_CTRL), 16'h0000);
    m_en[2] = 0; m_cont[2] = 0; m_ie[2] = 0;
    stop_and_check("collide");

    // Snapshot of a running 32-bit count, then reset in the middle of a scan
    for (int c = 1; c < NUM_CH; c++) cfg_ch(c, 32'd0, 3'b000);
    cfg_ch(0, 32'h0001_0000, 3'b001);
    start_run(4);
    wait_cyc(first_tick + 3 * tick_gap + 3);
    s = cyc;
    nt = (s - first_tick - 2) / tick_gap + 1;
    snap_read(0, v);
    check("snap_value", v, 32'h0001_0000 - 32'(nt));
    wait_cyc(first_tick + ((cyc - first_tick) / tick_gap + 1) * tick_gap + 2);
    check("mid_scan", 32'(bus_if.dbg_state), 32'(SCAN));
    reset_n = 1'b0;
    #1;
    check("async_rst_state", 32'(bus_if.dbg_state), 32'(IDLE));
    check("async_rst_readdata", 32'(bus_if.readdata), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    model_reset();
    bus_read(A_PRESCALE, d); check("rst2_prescale", 32'(d), 32'd49999);
    bus_read(A_GCTRL, d); check("rst2_gctrl", 32'(d), 32'd0);
    bus_read(A_STATUS, d); check("rst2_status", 32'(d), 32'd0);
    bus_read(ch_addr(0, CH_CTRL), d); check("rst2_ctrl", 32'(d), 32'd0);
    bus_read(ch_addr(0, CH_PERIOD_H), d); check("rst2_period_h", 32'(d), 32'd0);
    bus_read(ch_addr(0, CH_SNAP_L), d); check("rst2_snap_l", 32'(d), 32'd0);
    snap_read(0, v); check("rst2_count", v, m_count[0]);
    check("rst2_irq", 32'(bus_if.irq), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
